// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory loader and its RAM.
package imem_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: synchronous write from the loader, asynchronous read for fetch.
module imem_ram #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; contents are defined only by loader writes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: packs big-endian words into instruction memory, checks an
// XOR checksum and releases the core from reset only after a good load.
module imem_loader #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  import imem_pkg::*;

  localparam int CNT_W = ADDR_W + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam cnt_t       FULL_CNT  = cnt_t'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q;
  cnt_t                wcnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          csum_q;
  logic [DATA_W-9:0]   word_q;
  logic                accept;
  logic                word_end;
  logic [DATA_W-1:0]   packed_word;

  assign in_ready    = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
  assign accept      = in_valid && in_ready;
  assign word_end    = (byte_idx_q == LAST_BYTE);
  assign packed_word = {word_q, in_data};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COUNT;
      COUNT:   if (accept) state_d = DATA;
      DATA:    if (accept && word_end && (wcnt_q == cnt_t'(1))) state_d = CHECK;
      CHECK:   if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
      DONE,
      ERR:     if (start) state_d = COUNT;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst_n <= 1'b0;
    end else begin
      busy      <= (state_d == COUNT) || (state_d == DATA) || (state_d == CHECK);
      done      <= (state_d == DONE);
      err       <= (state_d == ERR);
      cpu_rst_n <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      csum_q     <= '0;
      word_q     <= '0;
      mem_we     <= 1'b0;
      mem_wa     <= '0;
      mem_wd     <= '0;
    end else begin
      mem_we <= 1'b0;
      if ((state_q == COUNT) && accept) begin
        // A count byte of zero stands for a full-depth load.
        wcnt_q     <= (in_data == 8'd0) ? FULL_CNT : cnt_t'(in_data);
        addr_q     <= '0;
        byte_idx_q <= '0;
        csum_q     <= '0;
      end
      if ((state_q == DATA) && accept) begin
        word_q     <= packed_word[DATA_W-9:0];
        csum_q     <= csum_q ^ in_data;
        byte_idx_q <= byte_idx_q + 2'd1;
        if (word_end) begin
          mem_we <= 1'b1;
          mem_wa <= addr_q;
          mem_wd <= packed_word;
          addr_q <= addr_q + 1'b1;
          wcnt_q <= wcnt_q - cnt_t'(1);
        end
      end
    end
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk (clk),
    .we  (mem_we),
    .wa  (mem_wa),
    .wd  (mem_wd),
    .ra  (ra),
    .rd  (rd)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-level reference model, table of
// randomized loads, and hand-written corner sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst_n;
  logic [7:0]  ra;
  logic [31:0] rd;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst_n (cpu_rst_n),
    .ra        (ra),
    .rd        (rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int n;
    bit corrupt;
    int gap_max;
    bit exp_done;
    bit exp_err;
    bit exp_cpu;
  } tcase_t;

  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [31:0] words[$];
  logic [31:0] mem_model [256];
  int          total    = 0;
  int          bad      = 0;
  int          n_writes = 0;
  int          stalls   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model expects, in order.
  always @(negedge clk) begin : write_monitor
    wr_t w;
    if (mem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got wa=%h wd=%h want none", mem_wa, mem_wd);
      end else begin
        w = exp_q.pop_front();
        check("write_addr", mem_wa, w.addr);
        check("write_data", mem_wd, w.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: stream layout and expected writes straight from the word list.
  task automatic build_stream(input bit corrupt);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    stream.delete();
    cs = 8'h00;
    stream.push_back(8'(words.size()));
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      for (int j = 3; j >= 0; j--) begin
        b = w[8*j +: 8];
        stream.push_back(b);
        cs = cs ^ b;
      end
      exp_q.push_back('{addr: 8'(k), data: w});
      mem_model[k] = w;
    end
    stream.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic run_load(input string tag, input int gap_max, input int poke_idx,
                          input bit exp_done, input bit exp_err, input bit exp_cpu);
    int w0;
    int nw;
    bit got;
    w0 = n_writes;
    nw = words.size();
    stalls = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_flags_clear"}, {done, err, cpu_rst_n}, 3'b000);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == poke_idx) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_poke"}, busy, 1'b1);
      end
      send_byte(stream[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    end
    got = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done || err) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_finished"}, got, 1'b1);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, exp_cpu);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_stalls"}, stalls, 0);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_write_count"}, n_writes - w0, nw);
    for (int k = 0; k < nw; k++) begin
      ra = 8'(k);
      #1;
      check({tag, "_readback"}, rd, mem_model[k]);
    end
    @(negedge clk);
  endtask

  tcase_t table_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    ra       = 8'h00;
    repeat (2) @(negedge clk);

    check("reset_in_ready", in_ready, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_mem_wa", mem_wa, 8'h00);
    check("reset_mem_wd", mem_wd, 32'h0);
    check("reset_flags", {busy, done, err, cpu_rst_n}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid while idle must be ignored.
    in_valid = 1'b1;
    in_data  = 8'h01;
    repeat (4) @(negedge clk);
    check("idle_valid_busy", busy, 1'b0);
    check("idle_valid_ready", in_ready, 1'b0);
    check("idle_valid_writes", n_writes, 0);
    in_valid = 1'b0;
    @(negedge clk);

    words = '{32'h20010003};
    build_stream(1'b0);
    run_load("single", 0, -1, 1'b1, 1'b0, 1'b1);

    words = '{32'h20010003, 32'h20020009};
    build_stream(1'b0);
    run_load("two_gaps", 3, -1, 1'b1, 1'b0, 1'b1);

    words = '{32'h20010003};
    build_stream(1'b1);
    check("bad_cs_byte", stream[5], 8'h23);
    run_load("bad_cs", 0, -1, 1'b0, 1'b1, 1'b0);
    build_stream(1'b0);
    run_load("recover", 0, -1, 1'b1, 1'b0, 1'b1);

    // Randomized word contents and gaps; expected flags are fixed per entry.
    table_q.push_back('{n: 1,  corrupt: 1'b0, gap_max: 0, exp_done: 1'b1, exp_err: 1'b0, exp_cpu: 1'b1});
    table_q.push_back('{n: 3,  corrupt: 1'b0, gap_max: 2, exp_done: 1'b1, exp_err: 1'b0, exp_cpu: 1'b1});
    table_q.push_back('{n: 2,  corrupt: 1'b1, gap_max: 0, exp_done: 1'b0, exp_err: 1'b1, exp_cpu: 1'b0});
    table_q.push_back('{n: 5,  corrupt: 1'b0, gap_max: 3, exp_done: 1'b1, exp_err: 1'b0, exp_cpu: 1'b1});
    table_q.push_back('{n: 4,  corrupt: 1'b1, gap_max: 1, exp_done: 1'b0, exp_err: 1'b1, exp_cpu: 1'b0});
    table_q.push_back('{n: 17, corrupt: 1'b0, gap_max: 1, exp_done: 1'b1, exp_err: 1'b0, exp_cpu: 1'b1});
    for (int t = 0; t < table_q.size(); t++) begin
      words.delete();
      for (int k = 0; k < table_q[t].n; k++) words.push_back($urandom());
      build_stream(table_q[t].corrupt);
      run_load($sformatf("table%0d", t), table_q[t].gap_max, -1,
               table_q[t].exp_done, table_q[t].exp_err, table_q[t].exp_cpu);
    end

    // start pulsed mid-stream (after count + first word) must be ignored.
    words = '{32'h20010003, 32'h20020009};
    build_stream(1'b0);
    run_load("start_busy", 0, 5, 1'b1, 1'b0, 1'b1);

    // Reset after two data bytes: nothing written, outputs back to reset values.
    begin
      int w0;
      logic [31:0] keep0;
      w0 = n_writes;
      keep0 = mem_model[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1'b0);
      check("midrst_mem_we", mem_we, 1'b0);
      check("midrst_mem_wa", mem_wa, 8'h00);
      check("midrst_mem_wd", mem_wd, 32'h0);
      check("midrst_flags", {busy, done, err, cpu_rst_n}, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_no_write", n_writes - w0, 0);
      ra = 8'h00;
      #1;
      check("midrst_mem0_kept", rd, keep0);
      @(negedge clk);
    end
    words = '{32'h8C010004};
    build_stream(1'b0);
    run_load("after_rst", 0, -1, 1'b1, 1'b0, 1'b1);

    // Full depth: count byte 0, word k = k at address k.
    words.delete();
    for (int k = 0; k < 256; k++) words.push_back(32'(k));
    build_stream(1'b0);
    check("full_count_byte", stream[0], 8'h00);
    run_load("full", 0, -1, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("full_no_extra_write", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake, packs the bytes big-endian into 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory starting at 0. It checks an XOR checksum at the end of the stream and holds the core in reset until the load completes successfully. It is the write-side counterpart to the combinational instruction-fetch path, which reads an 8-bit word address and returns a 32-bit instruction.

## Interface
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 32, instruction width; fixed at 32 (four bytes per word).
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_wa  out  ADDR_W  write word address.
- mem_wd  out  DATA_W  write data.
- busy  out  1  load in progress (COUNT, DATA or CHECK).
- done  out  1  last load succeeded; level, held until the next start.
- err  out  1  last load failed the checksum; level, held until the next start.
- cpu_rst_n  out  1  core reset; 0 unless state is DONE.

## Operation
- A byte is accepted on a cycle where in_valid && in_ready. in_ready is 1 only in COUNT, DATA and CHECK.
- Stream format: a count byte N (N=0 means 2^ADDR_W words), then 4·N data bytes with the MSB first in each word, then one checksum byte equal to the XOR of all 4·N data bytes. The count byte is excluded from the checksum.
- FSM states:
  - IDLE → COUNT on start.
  - COUNT: the accepted byte loads the word counter with N and clears the address, byte index and checksum accumulator → DATA.
  - DATA: each accepted byte shifts into the word register and is XORed into the accumulator. The byte index increments modulo 4. On the 4th byte, mem_we pulses on the next cycle with mem_wa = current address and mem_wd = the packed word. The address then increments and the word counter decrements. After the last word → CHECK.
  - CHECK: the accepted byte is compared with the accumulator. Equal → DONE (done=1). Unequal → ERR (err=1).
  - DONE and ERR → COUNT on start; done and err clear on that edge.
- Address arithmetic is unsigned ADDR_W bits. N=0 writes addresses 0 through 2^ADDR_W−1 exactly; the address wraps to 0 only after the final write, and that wrapped value is never used for a write.
- start while busy is ignored. in_valid while in_ready=0 is ignored, and no byte is consumed.
- Words written before an ERR stay in memory. cpu_rst_n stays 0 in ERR.
- A gap in in_valid stalls the FSM with no change to its state.

## Timing
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_wa=0, mem_wd=0, busy=0, done=0, err=0, cpu_rst_n=0.
- Reset asserted mid-load: the FSM returns to IDLE immediately. A pending mem_we is dropped; no partial word is written.
- All outputs are registered, with no combinational path from inputs to outputs. in_ready is decoded from the state register.
- Write latency: mem_we is high exactly one cycle, in the cycle after the 4th byte of the word is accepted.
- Throughput: one byte per cycle, with no bubbles between words or between the last data byte and the checksum byte.
- busy rises the cycle after start. done or err rises the cycle after the checksum byte is accepted, and cpu_rst_n rises with done.
- start and the count byte may not share a cycle. in_ready is 0 in the start cycle, so the count byte is taken at the earliest one cycle later.

## Structure
- Shared package imem_pkg holds the state enum (IDLE, COUNT, DATA, CHECK, DONE, ERR), ADDR_W/DATA_W defaults and BYTES_PER_WORD=4.
- Sub-module imem_ram: 2^ADDR_W × DATA_W with a synchronous write port (mem_we/mem_wa/mem_wd) and an asynchronous read port (8-bit address in, 32-bit RD out). It replaces the fixed instruction table, so the fetch path is unchanged.
- The loader itself is the FSM plus four counters/registers: byte index (2-bit), word counter (ADDR_W+1), address (ADDR_W), and checksum (8-bit).

## Test plan
- Single-word load: start, then bytes 01, 20 01 00 03, 22 → one mem_we with wa=0, wd=0x20010003; done=1, cpu_rst_n=1, err=0.
- Two words with in_valid gaps: bytes 02, 20 01 00 03, 20 02 00 09, 09 with random idle cycles → writes 0x20010003 at 0 and 0x20020009 at 1; done=1.
- Bad checksum: the single-word stream with checksum 0x23 → the word is still written at 0; err=1, done=0, cpu_rst_n=0. Then a start plus the correct stream → done=1, err=0.
- Full depth: N=00 followed by 1024 data bytes (word k = k) and the correct checksum → 256 writes at addresses 0..255, none after 255; done=1.
- Reset mid-word: rst_n low after 2 data bytes → no mem_we, all outputs at reset values. A new load then writes from address 0.
- start while busy and in_valid while in IDLE → both ignored; the stream and memory contents are unchanged.
